imm_operand_encoder: RTL
========================

Name: imm_operand_encoder

Overview:
- Multi-cycle encoder for the data-processing immediate: the inverse of the shifter-operand immediate decode.
- Takes a 32-bit constant and searches for a 4-bit rotate and 8-bit immediate such that ROR(imm8, 2*rot) equals the constant, using one rotation candidate per clock.
- Produces the 12-bit shifter_operand field {rot, imm8} or flags the constant as not encodable.
- Sits on the instruction-build path, upstream of the shifter, for assembler/self-test instruction generation.

Parameters:
- DATA_WIDTH, 32, operand width; only 32 is supported.
- IMM_WIDTH, 8, immediate field width.
- ROT_WIDTH, 4, rotate field width; the search covers 2**ROT_WIDTH candidates.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- value  input  32  constant to encode; captured when start is accepted.
- busy  output  1  high while searching.
- done  output  1  one-cycle pulse when a result is valid.
- encodable  output  1  1 = encoding found; 0 = constant not representable.
- shifter_operand  output  12  {rot[3:0], imm8[7:0]}; valid from done until the next accepted start.
- carry_out  output  1  imm-path shifter carry: value_reg[31] if rot!=0, else 0.

Behaviour:
- Reset: synchronous, active-high. When reset=1 at a clock edge: state=IDLE; busy=0, done=0, encodable=0, shifter_operand=12'h000, carry_out=0; value_reg and rot_cnt cleared. Reset during SEARCH aborts the search with no done pulse.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - start=1 at edge T: value_reg<=value, rot_cnt<=0, state<=SEARCH, busy=1 from T+1.
  - start=0: remain in IDLE.
- SEARCH, each cycle:
  - cand = ROL(value_reg, 2*rot_cnt), a 32-bit rotate with no sign or zero fill.
  - hit = (cand[31:8]==0).
  - hit: latch shifter_operand<={rot_cnt, cand[7:0]}, encodable<=1, carry_out<=(rot_cnt!=0)&value_reg[31], go to DONE.
  - no hit and rot_cnt==15: encodable<=0, shifter_operand<=12'h000, carry_out<=0, go to DONE.
  - otherwise rot_cnt<=rot_cnt+1. The 4-bit counter never wraps inside a search.
- Search order: the smallest rot that hits wins. value 0 encodes as rot=0, imm8=0.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - Result outputs hold until the next accepted start. They are not cleared on return to IDLE.
- Latency: start sampled at edge T, hit at candidate k, gives done high in cycle T+2+k. Miss gives done in cycle T+17. Minimum latency 2, maximum 17.
- start while busy or in DONE is ignored; there is no queueing.
- start held high across DONE→IDLE is accepted in the first IDLE cycle.
- value may change freely after acceptance; only value_reg is used.

Decomposition:
- Shared package: state encoding (IDLE/SEARCH/DONE), IMM_WIDTH, ROT_WIDTH, and the rotate-amount scaling constant (×2), all shared with the shifter decode.
- One natural sub-module: rol32, a combinational 32-bit rotate-left by a 5-bit amount. It is the mirror of the shifter's rotate-right case.

Test Plan:
- value=32'h00000005, start pulse → done 2 cycles after start, encodable=1, shifter_operand=12'h005, carry_out=0.
- value=32'hFF000000 → done at T+6, encodable=1, shifter_operand=12'h4FF, carry_out=1.
- value=32'hF000000F → shifter_operand=12'h2FF, carry_out=1. value=32'h00000104 → shifter_operand=12'hF41, done at T+17, carry_out=0.
- value=32'h00000101 → done at T+17, encodable=0, shifter_operand=12'h000, carry_out=0. Feed each encodable result back through the shifter immediate decode; the output must equal the original value.
- Start with value=32'h00000101, assert reset at T+5 for one cycle → no done pulse, all outputs 0, state IDLE. A new start with value=32'h000000FF → shifter_operand=12'h0FF.
- Start value=32'hFF000000, pulse start again with value=5 at T+3 → second start ignored, result 12'h4FF. Start held high continuously → back-to-back searches, done every (latency+1) cycles.

Source files
------------

// File: rtl/imm_operand_encoder_pkg.sv
// Shared definitions for the data-processing immediate encode/decode path:
// field widths, the rotate scaling factor and the encoder state encoding.
package imm_operand_encoder_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned IMM_WIDTH   = 8;
    localparam int unsigned ROT_WIDTH   = 4;
    localparam int unsigned ROT_SCALE   = 2;
    localparam int unsigned SHAMT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } enc_state_t;

    // Rotate field counts in units of two bit positions.
    function automatic logic [SHAMT_WIDTH-1:0] rot_amount(input logic [ROT_WIDTH-1:0] rot);
        return SHAMT_WIDTH'(rot) * SHAMT_WIDTH'(ROT_SCALE);
    endfunction

endpackage

// File: rtl/imm_operand_encoder_rol32.sv
// Combinational 32-bit rotate-left by a 5-bit amount; mirror of the
// shifter's rotate-right immediate decode.
module rol32
    import imm_operand_encoder_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic [SHAMT_WIDTH-1:0] amount,
    output logic [DATA_WIDTH-1:0]  result
);

    logic [2*DATA_WIDTH-1:0] doubled;

    // Shifting the doubled word left leaves the wrapped bits in the upper half.
    always_comb begin
        doubled = {data, data} << amount;
        result  = doubled[2*DATA_WIDTH-1:DATA_WIDTH];
    end

endmodule

// File: rtl/imm_operand_encoder.sv
// Multi-cycle search for {rot, imm8} with ROR(imm8, 2*rot) == value,
// trying one rotate candidate per clock, smallest rotate first.
module imm_operand_encoder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IMM_WIDTH  = 8,
    parameter int unsigned ROT_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [DATA_WIDTH-1:0]         value,
    output logic                          busy,
    output logic                          done,
    output logic                          encodable,
    output logic [ROT_WIDTH+IMM_WIDTH-1:0] shifter_operand,
    output logic                          carry_out
);

    import imm_operand_encoder_pkg::*;

    enc_state_t              state, state_next;
    logic [DATA_WIDTH-1:0]   value_reg;
    logic [DATA_WIDTH-1:0]   cand;
    logic [ROT_WIDTH-1:0]    rot_cnt;
    logic [SHAMT_WIDTH-1:0]  shamt;
    logic                    hit;
    logic                    last_cand;
    logic                    accept;
    logic                    latch_hit;
    logic                    latch_miss;
    logic                    advance;

    assign shamt = rot_amount(rot_cnt);

    rol32 u_rol32 (
        .data   (value_reg),
        .amount (shamt),
        .result (cand)
    );

    assign hit       = (cand[DATA_WIDTH-1:IMM_WIDTH] == '0);
    assign last_cand = (rot_cnt == '1);

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        latch_hit  = 1'b0;
        latch_miss = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
                busy = 1'b1;
                if (hit) begin
                    latch_hit  = 1'b1;
                    state_next = DONE;
                end else if (last_cand) begin
                    latch_miss = 1'b1;
                    state_next = DONE;
                end else begin
                    advance = 1'b1;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            value_reg       <= '0;
            rot_cnt         <= '0;
            encodable       <= 1'b0;
            shifter_operand <= '0;
            carry_out       <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                value_reg <= value;
                rot_cnt   <= '0;
            end
            if (advance) begin
                rot_cnt <= rot_cnt + 1'b1;
            end
            // Results persist through IDLE until the next search produces new ones.
            if (latch_hit) begin
                encodable       <= 1'b1;
                shifter_operand <= {rot_cnt, cand[IMM_WIDTH-1:0]};
                carry_out       <= (rot_cnt != '0) & value_reg[DATA_WIDTH-1];
            end
            if (latch_miss) begin
                encodable       <= 1'b0;
                shifter_operand <= '0;
                carry_out       <= 1'b0;
            end
        end
    end

endmodule
